// File: rtl/key_sideload_serializer.sv
// key_sideload_serializer
//
// Streams a sideloaded, share-split key out one WordWidth word at a time over
// a valid/ready handshake, then wipes the key register. With Unmask=0 every
// share is emitted raw, share-major; with Unmask=1 each beat is the XOR of
// all shares at that word index.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   key_valid_i  key offered on key_i
//   key_i        packed key, share s at [s*KeyWidth +: KeyWidth]
//   key_ready_o  key accepted this cycle (IDLE only)
//   clear_i      abort and wipe, wins over handshake / capture
//   word_valid_o word_o holds a key word
//   word_ready_i consumer accepts word_o
//   word_o       current word, zero whenever word_valid_o is low
//   word_idx_o   word index within the share
//   share_idx_o  share index (0 in unmask mode)
//   last_o       current word is the final beat
//   busy_o       not idle
//
// state  | meaning
// -------+--------------------------------------------------------------
// idle   | waiting for a key, key_ready_o high
// stream | presenting words, advancing on each handshake
// wipe   | one cycle of key/index clearing after the last beat

module key_sideload_serializer #(
   parameter int unsigned Shares    = 2,
   parameter int unsigned KeyWidth  = 64,
   parameter int unsigned WordWidth = 32,
   parameter bit          Unmask    = 1'b0,
   localparam int unsigned NumWords = KeyWidth / WordWidth,
   localparam int unsigned WIdxW    = (NumWords > 1) ? $clog2(NumWords) : 1,
   localparam int unsigned SIdxW    = (Shares > 1) ? $clog2(Shares) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       key_valid_i,
   input  logic [Shares*KeyWidth-1:0] key_i,
   output logic                       key_ready_o,
   input  logic                       clear_i,
   output logic                       word_valid_o,
   input  logic                       word_ready_i,
   output logic [WordWidth-1:0]       word_o,
   output logic [WIdxW-1:0]           word_idx_o,
   output logic [SIdxW-1:0]           share_idx_o,
   output logic                       last_o,
   output logic                       busy_o
);

   if ((KeyWidth % WordWidth) != 0 || Shares < 1) begin : gen_param_check
      $fatal(1, "key_sideload_serializer: KeyWidth must be a multiple of WordWidth and Shares >= 1");
   end

   localparam logic [WIdxW-1:0] last_word  = WIdxW'(NumWords - 1);
   localparam logic [SIdxW-1:0] last_share = SIdxW'(Shares - 1);

   typedef enum logic [1:0] {
      st_idle   = 2'd0,
      st_stream = 2'd1,
      st_wipe   = 2'd2
   } state_e;

   state_e                     state_q, state_d;
   logic [Shares*KeyWidth-1:0] key_q;
   logic [WIdxW-1:0]           word_idx_q;
   logic [SIdxW-1:0]           share_idx_q;
   logic                       capture;
   logic                       advance;
   logic                       at_last;
   logic [WordWidth-1:0]       word_sel;

   // Last beat is decided purely from registered indices so last_o never
   // depends on the consumer's ready.
   assign at_last = (word_idx_q == last_word) && (Unmask || share_idx_q == last_share);

   always_comb begin
      state_d      = state_q;
      capture      = 1'b0;
      advance      = 1'b0;
      key_ready_o  = 1'b0;
      word_valid_o = 1'b0;
      unique case (state_q)
         st_idle: begin
            key_ready_o = 1'b1;
            if (key_valid_i) begin
               capture = 1'b1;
               state_d = st_stream;
            end
         end
         st_stream: begin
            word_valid_o = 1'b1;
            if (word_ready_i) begin
               if (at_last) begin
                  state_d = st_wipe;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         st_wipe: begin
            state_d = st_idle;
         end
         default: begin
            state_d = st_idle;
         end
      endcase
      // clear discards any coincident beat or capture
      if (clear_i) begin
         state_d = st_idle;
         capture = 1'b0;
         advance = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= st_idle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         key_q       <= '0;
         word_idx_q  <= '0;
         share_idx_q <= '0;
      end else if (clear_i || state_q == st_wipe) begin
         key_q       <= '0;
         word_idx_q  <= '0;
         share_idx_q <= '0;
      end else if (capture) begin
         key_q       <= key_i;
         word_idx_q  <= '0;
         share_idx_q <= '0;
      end else if (advance) begin
         if (word_idx_q == last_word) begin
            word_idx_q <= '0;
            if (!Unmask) begin
               share_idx_q <= share_idx_q + 1'b1;
            end
         end else begin
            word_idx_q <= word_idx_q + 1'b1;
         end
      end
   end

   always_comb begin
      word_sel = '0;
      if (Unmask) begin
         for (int s = 0; s < int'(Shares); s++) begin
            word_sel = word_sel ^
               key_q[s*int'(KeyWidth) + int'(word_idx_q)*int'(WordWidth) +: WordWidth];
         end
      end else begin
         word_sel = key_q[int'(share_idx_q)*int'(KeyWidth) +
                          int'(word_idx_q)*int'(WordWidth) +: WordWidth];
      end
   end

   // Key bits only leave the block while a word is being presented.
   assign word_o      = word_valid_o ? word_sel : '0;
   assign word_idx_o  = word_idx_q;
   assign share_idx_o = share_idx_q;
   assign last_o      = word_valid_o && at_last;
   assign busy_o      = (state_q != st_idle);

endmodule

// File: tb/tb_key_sideload_serializer.sv
// Bench for key_sideload_serializer: one raw instance (Unmask=0) and one
// unmasking instance (Unmask=1) share clock, key, ready and clear; each has
// its own key_valid so either can be kept from recapturing.

module tb_key_sideload_serializer;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [127:0] key_in = '0;
   logic         kv0 = 1'b0, kv1 = 1'b0;
   logic         word_ready = 1'b0;
   logic         clear = 1'b0;

   logic        kr0, wv0, wi0, si0, lt0, by0;
   logic [31:0] wd0;
   logic        kr1, wv1, wi1, si1, lt1, by1;
   logic [31:0] wd1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   key_sideload_serializer #(.Shares(2), .KeyWidth(64), .WordWidth(32), .Unmask(1'b0)) dut (
      .clk_i(clk), .rst_ni(rst_n), .key_valid_i(kv0), .key_i(key_in), .key_ready_o(kr0),
      .clear_i(clear), .word_valid_o(wv0), .word_ready_i(word_ready), .word_o(wd0),
      .word_idx_o(wi0), .share_idx_o(si0), .last_o(lt0), .busy_o(by0));

   key_sideload_serializer #(.Shares(2), .KeyWidth(64), .WordWidth(32), .Unmask(1'b1)) dut_u (
      .clk_i(clk), .rst_ni(rst_n), .key_valid_i(kv1), .key_i(key_in), .key_ready_o(kr1),
      .clear_i(clear), .word_valid_o(wv1), .word_ready_i(word_ready), .word_o(wd1),
      .word_idx_o(wi1), .share_idx_o(si1), .last_o(lt1), .busy_o(by1));

   typedef struct packed {
      logic [31:0] word;
      logic        widx;
      logic        sidx;
      logic        last;
   } beat_t;

   beat_t exp_a [2][4];
   int    exp_n [2];
   beat_t obs_a [2][8];
   int    obs_n [2];
   int    lat   [2];

   // Reference: raw mode lists every share's words share-major, unmask mode
   // lists share0 ^ share1 per word index; last flag only on the final entry.
   task automatic build_model(input logic [127:0] k);
      logic [127:0] t;
      int n;
      n = 0;
      for (int s = 0; s < 2; s++) begin
         for (int w = 0; w < 2; w++) begin
            t = k >> (s*64 + w*32);
            exp_a[0][n].word = t[31:0];
            exp_a[0][n].widx = (w == 1);
            exp_a[0][n].sidx = (s == 1);
            exp_a[0][n].last = (n == 3);
            n++;
         end
      end
      exp_n[0] = 4;
      for (int w = 0; w < 2; w++) begin
         t = (k >> (w*32)) ^ (k >> (64 + w*32));
         exp_a[1][w].word = t[31:0];
         exp_a[1][w].widx = (w == 1);
         exp_a[1][w].sidx = 1'b0;
         exp_a[1][w].last = (w == 1);
      end
      exp_n[1] = 2;
   endtask

   function automatic logic [127:0] rand_key();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // mode 0: ready always high; 1: ready every 4th cycle; 2: random ready
   task automatic run_key(input logic [127:0] k, input int mode, input bit hold,
                          input logic [127:0] k2);
      int    ptr [2];
      bit    done [2];
      bit    stall_prev [2];
      beat_t prev [2];
      beat_t cur;
      logic  v, rk;
      build_model(k);
      for (int d = 0; d < 2; d++) begin
         ptr[d] = 0; done[d] = 1'b0; stall_prev[d] = 1'b0;
         prev[d] = '0; obs_n[d] = 0; lat[d] = -1;
      end
      @(negedge clk);
      checks++;
      if (kr0 !== 1'b1 || kr1 !== 1'b1) begin
         errors++;
         $display("FAIL idle_before_key: key_ready got %b/%b want 1/1", kr0, kr1);
      end
      key_in = k; kv0 = 1'b1; kv1 = 1'b1; word_ready = 1'b0;
      @(negedge clk);
      key_in = hold ? k2 : rand_key();
      kv0 = hold; kv1 = hold;
      for (int c = 1; c <= 200 && !(done[0] && done[1]); c++) begin
         if (c > 1) @(negedge clk);
         case (mode)
            0:       word_ready = 1'b1;
            1:       word_ready = ((c % 4) == 0);
            default: word_ready = ($urandom_range(0, 2) != 0);
         endcase
         for (int d = 0; d < 2; d++) begin
            if (!done[d]) begin
               v        = d ? wv1 : wv0;
               rk       = d ? kr1 : kr0;
               cur.word = d ? wd1 : wd0;
               cur.widx = d ? wi1 : wi0;
               cur.sidx = d ? si1 : si0;
               cur.last = d ? lt1 : lt0;
               if (stall_prev[d]) begin
                  checks++;
                  if (v !== 1'b1 || cur !== prev[d]) begin
                     errors++;
                     $display("FAIL stall_stable[%0d]: got v=%b %h/%b/%b/%b want v=1 %h/%b/%b/%b",
                              d, v, cur.word, cur.widx, cur.sidx, cur.last,
                              prev[d].word, prev[d].widx, prev[d].sidx, prev[d].last);
                  end
               end
               if (v === 1'b1) begin
                  checks++;
                  if (rk !== 1'b0) begin
                     errors++;
                     $display("FAIL ready_in_stream[%0d]: key_ready got %b want 0", d, rk);
                  end
                  checks++;
                  if (ptr[d] >= exp_n[d]) begin
                     errors++;
                     $display("FAIL extra_beat[%0d]: got word %h after %0d beats want none",
                              d, cur.word, exp_n[d]);
                  end else begin
                     if (cur !== exp_a[d][ptr[d]]) begin
                        errors++;
                        $display("FAIL beat[%0d][%0d]: got %h/w%b/s%b/l%b want %h/w%b/s%b/l%b",
                                 d, ptr[d], cur.word, cur.widx, cur.sidx, cur.last,
                                 exp_a[d][ptr[d]].word, exp_a[d][ptr[d]].widx,
                                 exp_a[d][ptr[d]].sidx, exp_a[d][ptr[d]].last);
                     end
                     if (word_ready) begin
                        obs_a[d][obs_n[d]] = cur;
                        obs_n[d]++;
                        ptr[d]++;
                     end
                  end
                  stall_prev[d] = !word_ready;
                  prev[d] = cur;
               end else begin
                  stall_prev[d] = 1'b0;
                  if (ptr[d] < exp_n[d]) begin
                     checks++; errors++;
                     $display("FAIL stream_gap[%0d]: valid got 0 at beat %0d want 1", d, ptr[d]);
                     done[d] = 1'b1;
                  end else if (rk === 1'b1) begin
                     lat[d] = c;
                     done[d] = 1'b1;
                     if (d == 0) kv0 = 1'b0; else kv1 = 1'b0;
                  end
               end
            end
         end
      end
      if (!(done[0] && done[1])) begin
         checks++; errors++;
         $display("FAIL stream_timeout: done got %b%b want 11", done[0], done[1]);
      end
      kv0 = 1'b0; kv1 = 1'b0; word_ready = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      checks++;
      if ({kr0, wv0, wd0, wi0, si0, lt0, by0} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL %s_raw: got kr=%b v=%b w=%h wi=%b si=%b l=%b b=%b want 1 0 0 0 0 0 0",
                  tag, kr0, wv0, wd0, wi0, si0, lt0, by0);
      end
      checks++;
      if ({kr1, wv1, wd1, wi1, si1, lt1, by1} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL %s_unmask: got kr=%b v=%b w=%h wi=%b si=%b l=%b b=%b want 1 0 0 0 0 0 0",
                  tag, kr1, wv1, wd1, wi1, si1, lt1, by1);
      end
   endtask

   task automatic test_reset();
      #12;
      check_idle_outputs("reset_held");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle_outputs("reset_released");
   endtask

   task automatic test_raw_directed();
      logic [31:0] want [4];
      want[0] = 32'h89abcdef; want[1] = 32'h01234567; want[2] = 32'h0; want[3] = 32'h0;
      run_key(128'h0123456789abcdef, 0, 1'b0, '0);
      checks++;
      if (obs_n[0] != 4) begin
         errors++;
         $display("FAIL raw_beat_count: got %0d want 4", obs_n[0]);
      end
      for (int i = 0; i < 4 && i < obs_n[0]; i++) begin
         checks++;
         if (obs_a[0][i].word !== want[i] || obs_a[0][i].last !== (i == 3) ||
             obs_a[0][i].widx !== (i % 2 == 1) || obs_a[0][i].sidx !== (i >= 2)) begin
            errors++;
            $display("FAIL raw_directed[%0d]: got %h l=%b want %h l=%b",
                     i, obs_a[0][i].word, obs_a[0][i].last, want[i], (i == 3));
         end
      end
      checks++;
      if (lat[0] != 6) begin
         errors++;
         $display("FAIL raw_ready_latency: got %0d want 6", lat[0]);
      end
   endtask

   task automatic test_unmask_directed();
      run_key({64'hffffffffffffffff, 64'h0123456789abcdef}, 0, 1'b0, '0);
      checks++;
      if (obs_n[1] != 2 ||
          obs_a[1][0] !== {32'h76543210, 1'b0, 1'b0, 1'b0} ||
          obs_a[1][1] !== {32'hfedcba98, 1'b1, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL unmask_directed: got n=%0d %h/%b %h/%b want 2 76543210/0 fedcba98/1",
                  obs_n[1], obs_a[1][0].word, obs_a[1][0].last, obs_a[1][1].word, obs_a[1][1].last);
      end
      checks++;
      if (lat[1] != 4) begin
         errors++;
         $display("FAIL unmask_ready_latency: got %0d want 4", lat[1]);
      end
   endtask

   task automatic test_backpressure();
      run_key(rand_key(), 1, 1'b0, '0);
      checks++;
      if (lat[0] != 18 || lat[1] != 10) begin
         errors++;
         $display("FAIL backpressure_latency: got %0d/%0d want 18/10", lat[0], lat[1]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         run_key(rand_key(), 2, 1'b0, '0);
      end
   endtask

   task automatic test_key_hold();
      run_key(rand_key(), 0, 1'b1, rand_key());
      run_key(rand_key(), 2, 1'b1, rand_key());
   endtask

   task automatic test_clear();
      logic [127:0] k;
      k = rand_key();
      build_model(k);
      @(negedge clk);
      key_in = k; kv0 = 1'b1; kv1 = 1'b1; word_ready = 1'b1;
      @(negedge clk);
      kv0 = 1'b0; kv1 = 1'b0;
      @(negedge clk);
      checks++;
      if (wv0 !== 1'b1 || wd0 !== exp_a[0][1].word) begin
         errors++;
         $display("FAIL clear_second_beat: got v=%b %h want v=1 %h", wv0, wd0, exp_a[0][1].word);
      end
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      word_ready = 1'b0;
      check_idle_outputs("after_clear");
      run_key(rand_key(), 0, 1'b0, '0);
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      key_in = rand_key(); kv0 = 1'b1; kv1 = 1'b1; word_ready = 1'b0;
      @(negedge clk);
      kv0 = 1'b0; kv1 = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      run_key(rand_key(), 0, 1'b0, '0);
      run_key(rand_key(), 2, 1'b0, '0);
   endtask

   initial begin
      test_reset();
      test_raw_directed();
      test_unmask_directed();
      test_backpressure();
      test_random();
      test_key_hold();
      test_clear();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
